// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame controller for an external 8-bit PISO shifter.
//   Accepts a byte over valid/ready, strobes the PISO load/shift, and sends
//   start, 8 data bits LSB first (from piso_y), optional parity, stop bit(s).
//   Optional feature macro: UART_PARITY_EN (adds the PARITY state and par_q).
//   Parameters: CLKS_PER_BIT (>=2), STOP_BITS (1 or 2), PARITY_ODD (0 even, 1 odd).
//   Ports: clk, rst (async active-low), tx_data/tx_valid/tx_ready (input byte),
//          piso_load/piso_shift/piso_y (PISO link), tx (serial line), busy.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       piso_load,
  output logic       piso_shift,
  input  logic       piso_y,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic wrap;
  assign wrap = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign piso_load = tx_valid & tx_ready;
  // Shift at the end of START and of data bits 0..6 so piso_y leads each bit.
  assign piso_shift = wrap & ((state_q == START) | ((state_q == DATA) & (bit_q != 3'd7)));
`ifdef UART_PARITY_EN
  logic par_q, par_d;
  assign par_d = piso_load ? (^tx_data) ^ PARITY_ODD : par_q;
  assign tx = (state_q == START) ? 1'b0 : (state_q == DATA) ? piso_y : (state_q == PARITY) ? par_q : 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_q <= 1'b0;
    else par_q <= par_d;
`else
  logic unused;
  assign unused = ^{PARITY_ODD, tx_data};
  assign tx = (state_q == START) ? 1'b0 : (state_q == DATA) ? piso_y : 1'b1;
`endif
  // bit_q counts data bits in DATA, then stop bits in STOP (it wraps 7->0 on leaving DATA).
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        state_d = piso_load ? START : IDLE;
      end
      START: state_d = wrap ? DATA : START;
      DATA: if (wrap) begin
        bit_d = bit_q + 3'd1;
`ifdef UART_PARITY_EN
        state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
        state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: state_d = wrap ? STOP : PARITY;
`endif
      STOP: if (wrap) begin
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'(STOP_BITS - 1)) ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: random + directed bench with a frame-queue reference model and a PISO model.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  localparam int N = 4;
  localparam int SB = 1;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
  localparam int READY_CYC = 45;
`else
  localparam int FB = 10;
  localparam int READY_CYC = 41;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic piso_y = 1'b1;
  logic [7:0] sr = 8'h00;
  logic tx_ready, piso_load, piso_shift, tx, busy;
  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic sh_q[$];
  always #5 clk = ~clk;
  uart_tx_ctrl #(.CLKS_PER_BIT(N), .STOP_BITS(SB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .piso_load(piso_load), .piso_shift(piso_shift), .piso_y(piso_y), .tx(tx), .busy(busy)
  );
  always @(posedge clk)
    if (piso_load) sr <= tx_data;
    else if (piso_shift) begin
      piso_y <= sr[0];
      sr <= {1'b0, sr[7:1]};
    end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic push_frame(input logic [7:0] b);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9] = ^b;
`endif
    for (int p = 0; p < FB + SB - 1; p++)
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(f[p]);
        sh_q.push_back(i == N - 1 && p <= 7);
      end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      sh_q.delete();
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_shift", piso_shift, 0);
    end else if (exp_q.size() == 0) begin
      chk("idle_tx", tx, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_shift", piso_shift, 0);
      chk("idle_load", piso_load, tx_valid);
      if (tx_valid) push_frame(tx_data);
    end else begin
      chk("frame_tx", tx, exp_q.pop_front());
      chk("frame_shift", piso_shift, sh_q.pop_front());
      chk("frame_ready", tx_ready, 0);
      chk("frame_busy", busy, 1);
      chk("frame_load", piso_load, 0);
    end
  end
  task automatic wait_idle();
    @(negedge clk);
    for (int k = 0; k < 200 && !tx_ready; k++) @(negedge clk);
    if (!tx_ready) chk("idle_timeout", tx_ready, 1);
  endtask
  task automatic capture(input logic [7:0] b, output logic [15:0] bits, output int rc,
                         output logic [63:0] sm, output int ld0, output int nld);
    bits = '0;
    sm = '0;
    rc = -1;
    nld = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = b;
    @(negedge clk);
    ld0 = int'(piso_load);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    for (int c = 1; c <= 80 && rc < 0; c++) begin
      @(negedge clk);
      if ((c - 1) % N == N / 2 && (c - 1) / N < 16) bits[(c - 1) / N] = tx;
      if (piso_shift && c < 64) sm[c] = 1'b1;
      if (piso_load) nld++;
      if (tx_ready) rc = c;
    end
  endtask
  initial begin
    logic [15:0] bits;
    logic [63:0] sm;
    int rc, ld0, nld;
    repeat (3) @(negedge clk);
    chk("t1_tx", tx, 1);
    chk("t1_ready", tx_ready, 1);
    chk("t1_busy", busy, 0);
    chk("t1_shift", piso_shift, 0);
    chk("t1_load", piso_load, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_hold_tx", tx, 1);
    chk("t1_hold_busy", busy, 0);
    wait_idle();
    capture(8'hA5, bits, rc, sm, ld0, nld);
`ifdef UART_PARITY_EN
    chk("a5_bits", bits[FB-1:0], 11'b10101001010);
`else
    chk("a5_bits", bits[FB-1:0], 10'b1101001010);
`endif
    chk("a5_ready_cycle", rc, READY_CYC);
    chk("a5_load_accept", ld0, 1);
    chk("a5_load_other", nld, 0);
    chk("a5_shift_cycles", sm, 64'h0000_0001_1111_1110);
`ifdef UART_PARITY_EN
    wait_idle();
    capture(8'h01, bits, rc, sm, ld0, nld);
    chk("p01_bits", bits[FB-1:0], 11'b11000000010);
    chk("p01_ready_cycle", rc, 45);
`endif
    wait_idle();
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 8'h00;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    rc = -1;
    for (int c = 1; c <= 80 && rc < 0; c++) begin
      @(negedge clk);
      if (piso_load) begin
        rc = c;
        chk("b2b_gap_tx", tx, 1);
      end
    end
    chk("b2b_accept_cycle", rc, READY_CYC);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start_tx", tx, 0);
    chk("b2b_start_busy", busy, 1);
    wait_idle();
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_busy_before", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_tx", tx, 1);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_after_ready", tx_ready, 1);
    capture(8'h3C, bits, rc, sm, ld0, nld);
`ifdef UART_PARITY_EN
    chk("t6_bits", bits[FB-1:0], 11'b10001111000);
`else
    chk("t6_bits", bits[FB-1:0], 10'b1001111000);
`endif
    chk("t6_ready_cycle", rc, READY_CYC);
    wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      tx_valid = $urandom_range(0, 3) != 0;
      tx_data = 8'($urandom);
      rst = $urandom_range(0, 799) != 0;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    rst = 1'b1;
    wait_idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
